// File: rtl/traffic_pkg.sv
// Definitions shared by the traffic light FSM and its phase-duration timer.
package traffic_pkg;

  // Bit positions inside the FSM's one-hot enableCounters request.
  localparam int unsigned EN_GREEN  = 0;
  localparam int unsigned EN_YELLOW = 1;
  localparam int unsigned EN_RED    = 2;
  localparam int unsigned EN_PED    = 3;
  localparam int unsigned EN_W      = 4;

  // Phase timer state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } timer_state_e;

  // The FSM's currentState encoding, kept here so both ends agree on it.
  typedef enum logic [2:0] {
    FSM_GREEN   = 3'd0,
    FSM_YELLOW  = 3'd1,
    FSM_RED     = 3'd2,
    FSM_PED     = 3'd3,
    FSM_ALL_RED = 3'd4
  } fsm_state_e;

  // True when exactly one request bit is set.
  function automatic logic is_one_hot(input logic [EN_W-1:0] v);
    return (v != '0) && ((v & (v - EN_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down counter that stops at zero; load has priority over decrement.
module phase_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         zero_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load, else decrement while enabled and not yet at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_c  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_timer.sv
// Times the phase requested by the traffic FSM and pulses triggerNextEvent on expiry.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned RED_TICKS    = 16,
  parameter int unsigned PED_TICKS    = 12,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       enableCounters,
  output logic             triggerNextEvent,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             err
);

  timer_state_e     state_q, state_d;
  logic [EN_W-1:0]  prev_en_q;
  logic             trig_q, trig_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic             new_req;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] dur_m1;

  // Reload value is D-1; a zero-tick parameter still times one cycle.
  function automatic logic [CNT_W-1:0] ticks_to_reload(input int unsigned ticks);
    return (ticks == 0) ? '0 : CNT_W'(ticks - 1);
  endfunction

  assign new_req = (enableCounters != prev_en_q);

  // Duration select from the (one-hot) request bit.
  always_comb begin
    dur_m1 = '0;
    if (enableCounters[EN_GREEN]) begin
      dur_m1 = ticks_to_reload(GREEN_TICKS);
    end else if (enableCounters[EN_YELLOW]) begin
      dur_m1 = ticks_to_reload(YELLOW_TICKS);
    end else if (enableCounters[EN_RED]) begin
      dur_m1 = ticks_to_reload(RED_TICKS);
    end else if (enableCounters[EN_PED]) begin
      dur_m1 = ticks_to_reload(PED_TICKS);
    end
  end

  // Next state; a request change always wins over expiry in the same cycle.
  always_comb begin
    state_d      = state_q;
    trig_d       = 1'b0;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (new_req) begin
      cnt_load = 1'b1;
      if (enableCounters == '0) begin
        state_d = IDLE;
      end else if (!is_one_hot(enableCounters)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        state_d      = COUNT;
        cnt_load_val = dur_m1;
      end
    end else begin
      unique case (state_q)
        COUNT: begin
          if (cnt_zero) begin
            trig_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        IDLE, DONE: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end
  end

  // State, request history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_en_q <= '0;
      trig_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_en_q <= enableCounters;
      trig_q    <= trig_d;
      err_q     <= err_d;
      busy_q    <= (state_d == COUNT);
    end
  end

  phase_down_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_val),
    .en_i         (cnt_dec),
    .count_o      (remaining),
    .zero_c       (cnt_zero)
  );

  assign triggerNextEvent = trig_q;
  assign busy             = busy_q;
  assign err              = err_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with hand-computed pulse timings.
module tb_traffic_phase_timer;

  logic       clk;
  logic       reset;
  logic [3:0] en;
  logic       trig;
  logic [7:0] remaining;
  logic       busy;
  logic       err;

  int tests;
  int fails;

  traffic_phase_timer dut (
    .clk              (clk),
    .reset            (reset),
    .enableCounters   (en),
    .triggerNextEvent (trig),
    .remaining        (remaining),
    .busy             (busy),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges after the call until trig is seen; -1 if the budget runs out.
  task automatic wait_trig(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (trig === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    en    = 4'b0001;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({trig, remaining, busy, err} !== 11'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: trig=%b rem=%0d busy=%b err=%b, want all 0", i, trig, remaining, busy, err);
      end
    end
    reset = 1'b0;
    // Sampling edge plus 20 edges.
    wait_trig(100, n);
    tests++;
    if (n !== 21) begin
      fails++;
      $display("FAIL reset_green_latency: got %0d edges, want 21", n);
    end
    tick();
    tests++;
    if (trig !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulse_width: trig=%b, want 0", trig);
    end
  endtask

  task automatic test_sequence();
    int n;
    en = 4'b0010;
    wait_trig(100, n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL seq_yellow: got %0d, want 5", n);
    end
    en = 4'b0100;
    wait_trig(100, n);
    tests++;
    if (n !== 17) begin
      fails++;
      $display("FAIL seq_red: got %0d, want 17", n);
    end
    en = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests++;
      if (remaining !== 8'(20 - k) || busy !== 1'b1 || trig !== 1'b0) begin
        fails++;
        $display("FAIL seq_green_rem[%0d]: rem=%0d busy=%b trig=%b, want rem=%0d busy=1 trig=0", k, remaining, busy, trig, 20 - k);
      end
    end
    tick();
    tests++;
    if (trig !== 1'b1 || remaining !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL seq_green_expiry: trig=%b rem=%0d busy=%b, want 1/0/0", trig, remaining, busy);
    end
  endtask

  task automatic test_hold();
    int n;
    int pulses;
    en = 4'b0010;
    wait_trig(100, n);
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL hold_yellow: got %0d, want 5", n);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (trig === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL hold_retrigger: extra pulses=%0d, want 0", pulses);
    end
    tests++;
    if (busy !== 1'b0 || remaining !== 8'd0) begin
      fails++;
      $display("FAIL hold_done_outputs: busy=%b rem=%0d, want 0/0", busy, remaining);
    end
  endtask

  task automatic test_abort();
    int n;
    int guard;
    en = 4'b0001;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (remaining !== 8'd5 && guard < 100);
    tests++;
    if (guard !== 15 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_reach_5: edges=%0d busy=%b, want 15/1", guard, busy);
    end
    en = 4'b1000;
    wait_trig(100, n);
    tests++;
    if (n !== 13) begin
      fails++;
      $display("FAIL abort_ped_latency: got %0d, want 13", n);
    end
    // Collision: change request on the yellow expiry edge.
    en = 4'b0010;
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (remaining !== 8'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL collide_pre: rem=%0d busy=%b, want 0/1", remaining, busy);
    end
    en = 4'b0100;
    tick();
    tests++;
    if (trig !== 1'b0 || remaining !== 8'd15 || busy !== 1'b1) begin
      fails++;
      $display("FAIL collide_reload: trig=%b rem=%0d busy=%b, want 0/15/1", trig, remaining, busy);
    end
    wait_trig(100, n);
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL collide_red_latency: got %0d, want 16", n);
    end
  endtask

  task automatic test_error();
    int n;
    int pulses;
    en = 4'b0101;
    tick();
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || remaining !== 8'd0 || trig !== 1'b0) begin
      fails++;
      $display("FAIL err_multihot: err=%b busy=%b rem=%0d trig=%b, want 1/0/0/0", err, busy, remaining, trig);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (trig === 1'b1 || busy === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL err_held_idle: activity cycles=%0d, want 0", pulses);
    end
    en = 4'b0100;
    wait_trig(100, n);
    tests++;
    if (n !== 17 || err !== 1'b1) begin
      fails++;
      $display("FAIL err_recover_red: got %0d err=%b, want 17 err=1", n, err);
    end
  endtask

  task automatic test_midcount_reset();
    int n;
    int guard;
    en = 4'b0001;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (remaining !== 8'd7 && guard < 100);
    tests++;
    if (guard !== 13) begin
      fails++;
      $display("FAIL midreset_reach_7: edges=%0d, want 13", guard);
    end
    #3;
    reset = 1'b1;
    en    = 4'b0100;
    #1;
    tests++;
    if ({trig, remaining, busy, err} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_async: trig=%b rem=%0d busy=%b err=%b, want all 0", trig, remaining, busy, err);
    end
    tick();
    tick();
    reset = 1'b0;
    wait_trig(100, n);
    tests++;
    if (n !== 17 || err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_restart: got %0d err=%b, want 17 err=0", n, err);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    en    = 4'b0000;
    test_reset();
    test_sequence();
    test_hold();
    test_abort();
    test_error();
    test_midcount_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
